// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the cpu6502
// core and a single DMA requester. The CPU owns the port by default and is
// stalled through cpu_ready while the DMA requester holds it. CPU accesses to
// IO_ADDR are steered to the io port instead of memory. DMA accesses are never
// io-decoded.
module mem_arbiter #(
    parameter int unsigned CPU_SLICE = 8,
    parameter int unsigned DMA_BURST = 4,
    parameter logic [15:0] IO_ADDR   = 16'hbffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic [7:0]  cpu_rdata,
    input  logic [7:0]  io_rdata,
    output logic        io_we,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_we,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    // Counter widths sized so the terminal count (N-1) always fits, minimum one bit.
    localparam int unsigned RUN_W   = (CPU_SLICE > 1) ? $clog2(CPU_SLICE) : 1;
    localparam int unsigned BURST_W = (DMA_BURST > 1) ? $clog2(DMA_BURST) : 1;

    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(CPU_SLICE - 1);
    localparam logic [RUN_W-1:0]   RUN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0]   RUN_ZERO   = RUN_W'(0);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(DMA_BURST - 1);
    localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);
    localparam logic [BURST_W-1:0] BURST_ZERO = BURST_W'(0);

    typedef enum logic {
        ST_CPU = 1'b0,
        ST_DMA = 1'b1
    } state_t;

    state_t             state_r;
    logic [RUN_W-1:0]   run_cnt_r;
    logic [BURST_W-1:0] burst_cnt_r;
    logic               dma_rvalid_r;
    logic               rd_io_r;

    logic               io_hit_s;
    logic               dma_ack_s;

    assign io_hit_s  = (cpu_addr == IO_ADDR);
    // A DMA access is taken on any cycle the port is owned by DMA and a request is pending.
    assign dma_ack_s = (state_r == ST_DMA) && dma_req;

    // Port owner FSM: slice/burst counters, DMA read-valid pulse and io read steering flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_CPU;
            run_cnt_r    <= RUN_ZERO;
            burst_cnt_r  <= BURST_ZERO;
            dma_rvalid_r <= 1'b0;
            rd_io_r      <= 1'b0;
        end else begin
            dma_rvalid_r <= dma_ack_s && !dma_we;
            rd_io_r      <= (state_r == ST_CPU) && io_hit_s;
            case (state_r)
                ST_CPU: begin
                    if (dma_req) begin
                        if (run_cnt_r == RUN_LAST) begin
                            state_r   <= ST_DMA;
                            run_cnt_r <= RUN_ZERO;
                        end else begin
                            run_cnt_r <= run_cnt_r + RUN_ONE;
                        end
                    end else begin
                        run_cnt_r <= RUN_ZERO;
                    end
                end
                ST_DMA: begin
                    if (!dma_req) begin
                        // Requester withdrew (or never showed up): hand the port back.
                        state_r     <= ST_CPU;
                        burst_cnt_r <= BURST_ZERO;
                    end else if (burst_cnt_r == BURST_LAST) begin
                        state_r     <= ST_CPU;
                        burst_cnt_r <= BURST_ZERO;
                    end else begin
                        burst_cnt_r <= burst_cnt_r + BURST_ONE;
                    end
                end
                default: begin
                    state_r     <= ST_CPU;
                    run_cnt_r   <= RUN_ZERO;
                    burst_cnt_r <= BURST_ZERO;
                end
            endcase
        end
    end

    // Memory/io port steering by current owner, plus read data return paths.
    always_comb begin
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_we     = 1'b0;
        io_we      = 1'b0;
        dma_ack    = 1'b0;
        cpu_ready  = 1'b1;
        if (state_r == ST_DMA) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_ack_s && dma_we;
            io_we     = 1'b0;
            dma_ack   = dma_ack_s;
            cpu_ready = 1'b0;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we && !io_hit_s;
            io_we     = cpu_we && io_hit_s;
            dma_ack   = 1'b0;
            cpu_ready = 1'b1;
        end
        cpu_rdata  = rd_io_r ? io_rdata : mem_rdata;
        dma_rdata  = mem_rdata;
        dma_rvalid = dma_rvalid_r;
    end

endmodule
